// File: rtl/core_pkg.sv
// Shared definitions for the core register file slice.
//   - Register index constants for the SP/LR/PC aliases of the Rd write port.
//   - APSR flag bit positions within the 4-bit NZCV field.
//   - Reset value of LR and the alignment masks applied to SP and PC writes.
//   - Vector-fetch sequencer state enum and the load-pulse bundle it emits.
package core_pkg;

  localparam logic [3:0] REG_SP = 4'd13;
  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  localparam int APSR_N = 3;
  localparam int APSR_Z = 2;
  localparam int APSR_C = 1;
  localparam int APSR_V = 0;

  localparam logic [31:0] LR_RESET = 32'hFFFF_FFFF;
  localparam logic [31:0] SP_MASK  = 32'hFFFF_FFFC;  // SP is word aligned
  localparam logic [31:0] PC_MASK  = 32'hFFFF_FFFE;  // PC is halfword aligned

  typedef enum logic [1:0] {
    FETCH_SP = 2'd0,
    FETCH_PC = 2'd1,
    RUN      = 2'd2
  } vec_state_e;

  // One-cycle load pulses from the vector loader into the register file.
  typedef struct packed {
    logic        sp;
    logic        pc;
    logic [31:0] data;
  } vec_load_t;

endpackage

// File: rtl/core_vector_loader.sv
// Reset-time vector fetch sequencer.
// Reads the initial SP from RESET_VTOR and the initial PC from RESET_VTOR+4
// over a req/ack handshake, then parks in RUN and raises core_ready.
// Ports:
//   clk, rst               clock, async active-high reset
//   vec_req, vec_addr      read request / address, stable until ack
//   vec_ack, vec_rdata     read completion, honoured only while vec_req=1
//   core_ready             high once both vectors are loaded
//   vec_load               one-cycle SP/PC load pulses plus the vector word
module core_vector_loader
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_VTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vec_ack,
  input  logic [31:0] vec_rdata,
  output logic        vec_req,
  output logic [31:0] vec_addr,
  output logic        core_ready,
  output vec_load_t   vec_load
);

  vec_state_e state, state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH_SP;
    else     state <= state_next;
  end

  // vec_req is gated by rst so it is low during reset and drops the moment
  // reset is asserted, even with a request outstanding.
  always_comb begin
    state_next    = state;
    vec_req       = 1'b0;
    vec_addr      = RESET_VTOR;
    core_ready    = 1'b0;
    vec_load.sp   = 1'b0;
    vec_load.pc   = 1'b0;
    vec_load.data = vec_rdata;
    case (state)
      FETCH_SP: begin
        vec_req = ~rst;
        if (vec_ack && !rst) begin
          vec_load.sp = 1'b1;
          state_next  = FETCH_PC;
        end
      end
      FETCH_PC: begin
        vec_req  = ~rst;
        vec_addr = RESET_VTOR + 32'd4;
        if (vec_ack && !rst) begin
          vec_load.pc = 1'b1;
          state_next  = RUN;
        end
      end
      RUN:     core_ready = 1'b1;
      default: state_next = FETCH_SP;
    endcase
  end

endmodule

// File: rtl/core_register_file.sv
// Architectural register state: R0-R12, SP (MSP), LR, PC, APSR, IPSR, PRIMASK.
// Initial SP/PC come from the vector loader; afterwards the control unit's
// ld_* strobes and pc_inc update state on the next rising edge.
// Ports:
//   clk, rst                      clock, async active-high reset
//   vec_req/vec_addr/vec_ack/vec_rdata  vector-table read handshake
//   core_ready                    vector fetch done, strobes honoured
//   ld_sp/ld_lr/ld_pc/ld_rd/ld_apsr/ld_ipsr/ld_primask, pc_inc  update strobes
//   wr_addr, wdata                Rd destination and write data
//   apsr_in, ipsr_in, primask_in  next special-register values
//   ra_addr/ra_data, rb_addr/rb_data  combinational read ports (15 -> PC+4)
//   sp, lr, pc, apsr, ipsr, primask  direct state outputs
//   tbit_err                      reset PC vector had bit0 clear
module core_register_file
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_VTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        vec_req,
  output logic [31:0] vec_addr,
  input  logic        vec_ack,
  input  logic [31:0] vec_rdata,
  output logic        core_ready,
  input  logic        ld_sp,
  input  logic        ld_lr,
  input  logic        ld_pc,
  input  logic        ld_rd,
  input  logic        ld_apsr,
  input  logic        ld_ipsr,
  input  logic        ld_primask,
  input  logic        pc_inc,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  apsr_in,
  input  logic [5:0]  ipsr_in,
  input  logic        primask_in,
  input  logic [3:0]  ra_addr,
  input  logic [3:0]  rb_addr,
  output logic [31:0] ra_data,
  output logic [31:0] rb_data,
  output logic [31:0] sp,
  output logic [31:0] lr,
  output logic [31:0] pc,
  output logic [3:0]  apsr,
  output logic [5:0]  ipsr,
  output logic        primask,
  output logic        tbit_err
);

  vec_load_t vec_load;

  core_vector_loader #(.RESET_VTOR(RESET_VTOR)) u_loader (
    .clk        (clk),
    .rst        (rst),
    .vec_ack    (vec_ack),
    .vec_rdata  (vec_rdata),
    .vec_req    (vec_req),
    .vec_addr   (vec_addr),
    .core_ready (core_ready),
    .vec_load   (vec_load)
  );

  logic [31:0] gpr [13];
  logic        run;
  logic        rd_sp, rd_lr, rd_pc;

  assign run   = core_ready;
  assign rd_sp = run && ld_rd && (wr_addr == REG_SP);
  assign rd_lr = run && ld_rd && (wr_addr == REG_LR);
  assign rd_pc = run && ld_rd && (wr_addr == REG_PC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 13; i++) gpr[i] <= '0;
    end else if (run && ld_rd) begin
      for (int i = 0; i < 13; i++)
        if (wr_addr == i[3:0]) gpr[i] <= wdata;
    end
  end

  // Dedicated and aliased writes carry the same wdata and mask, so merging
  // them is equivalent to the dedicated strobe winning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         sp <= '0;
    else if (vec_load.sp)            sp <= vec_load.data & SP_MASK;
    else if (run && (ld_sp || rd_sp)) sp <= wdata & SP_MASK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         lr <= LR_RESET;
    else if (run && (ld_lr || rd_lr)) lr <= wdata;
  end

  // Any PC load beats pc_inc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         pc <= '0;
    else if (vec_load.pc)            pc <= vec_load.data & PC_MASK;
    else if (run && (ld_pc || rd_pc)) pc <= wdata & PC_MASK;
    else if (run && pc_inc)          pc <= pc + 32'd2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      apsr     <= '0;
      ipsr     <= '0;
      primask  <= 1'b0;
      tbit_err <= 1'b0;
    end else begin
      if (run && ld_apsr)    apsr    <= apsr_in;
      if (run && ld_ipsr)    ipsr    <= ipsr_in;
      if (run && ld_primask) primask <= primask_in;
      if (vec_load.pc)       tbit_err <= ~vec_load.data[0];
    end
  end

  // Flat 16-entry read view; entry 15 is the Thumb pipeline PC (PC+4).
  logic [31:0] rview [16];
  always_comb begin
    for (int i = 0; i < 13; i++) rview[i] = gpr[i];
    rview[13] = sp;
    rview[14] = lr;
    rview[15] = pc + 32'd4;
  end

  assign ra_data = rview[ra_addr];
  assign rb_data = rview[rb_addr];

endmodule
